// File: rtl/spi_master_ctrl.sv
// SPI master (standard/quad) with CS setup/hold. Done follows start by 1+H*(2+2N) clk cycles.
// start is taken only in IDLE and ignored while busy; there is no backpressure on the SPI side.
module spi_master_ctrl #(
  parameter int CLK_DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 quad_en,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic [5:0]           tx_len,
  input  logic [5:0]           rx_len,
  input  logic [31:0]          tx_data,
  output logic [31:0]          rx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 spi_clk,
  output logic                 spi_csn,
  output logic [3:0]           spi_sdo,
  output logic [3:0]           spi_oe,
  input  logic [3:0]           spi_sdi
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, TX, RX, CS_HOLD} state_t;

  state_t               state;
  logic [CLK_DIV_W-1:0] div_q;
  logic [CLK_DIV_W-1:0] hcnt;
  logic                 quad_q;
  logic [31:0]          tx_sh;
  logic [5:0]           tx_left;
  logic [5:0]           rx_left;

  logic [5:0]  tx_eff, rx_eff, step;
  logic        half_end;
  logic [3:0]  first_grp, next_grp;
  logic [31:0] rx_shift;

  // Lengths are clamped to 32 and, in quad mode, floored to whole nibbles.
  function automatic logic [5:0] eff_len(input logic [5:0] len, input logic quad);
    logic [5:0] l;
    l = (len > 6'd32) ? 6'd32 : len;
    if (quad) l[1:0] = 2'b00;
    return l;
  endfunction

  always_comb begin
    tx_eff    = eff_len(tx_len, quad_en);
    rx_eff    = eff_len(rx_len, quad_en);
    step      = quad_q ? 6'd4 : 6'd1;
    half_end  = (hcnt == div_q);
    first_grp = quad_en ? tx_data[31:28] : {3'b000, tx_data[31]};
    next_grp  = quad_q ? tx_sh[27:24] : {3'b000, tx_sh[30]};
    rx_shift  = quad_q ? {rx_data[27:0], spi_sdi} : {rx_data[30:0], spi_sdi[0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_q   <= '0;
      hcnt    <= '0;
      quad_q  <= 1'b0;
      tx_sh   <= '0;
      tx_left <= '0;
      rx_left <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      spi_clk <= 1'b0;
      spi_csn <= 1'b1;
      spi_sdo <= '0;
      spi_oe  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CS_SETUP;
            div_q   <= clk_div;
            hcnt    <= '0;
            quad_q  <= quad_en;
            tx_sh   <= tx_data;
            tx_left <= tx_eff;
            rx_left <= rx_eff;
            rx_data <= '0;
            busy    <= 1'b1;
            spi_csn <= 1'b0;
            spi_sdo <= (tx_eff != 6'd0) ? first_grp : 4'h0;
            spi_oe  <= (tx_eff == 6'd0) ? 4'h0 : (quad_en ? 4'hF : 4'h1);
          end
        end
        CS_SETUP: begin
          if (half_end) begin
            hcnt <= '0;
            if (tx_left != 6'd0)      state <= TX;
            else if (rx_left != 6'd0) state <= RX;
            else                      state <= CS_HOLD;
          end else begin
            hcnt <= hcnt + CLK_DIV_W'(1);
          end
        end
        TX, RX: begin
          if (!half_end) begin
            hcnt <= hcnt + CLK_DIV_W'(1);
          end else begin
            hcnt    <= '0;
            spi_clk <= ~spi_clk;
            // Input is captured at the same edge that raises spi_clk.
            if (!spi_clk) begin
              if (state == RX) rx_data <= rx_shift;
            end else if (state == TX) begin
              tx_sh   <= quad_q ? {tx_sh[27:0], 4'h0} : {tx_sh[30:0], 1'b0};
              tx_left <= tx_left - step;
              if (tx_left == step) begin
                spi_sdo <= 4'h0;
                spi_oe  <= 4'h0;
                state   <= (rx_left != 6'd0) ? RX : CS_HOLD;
              end else begin
                spi_sdo <= next_grp;
              end
            end else begin
              rx_left <= rx_left - step;
              if (rx_left == step) state <= CS_HOLD;
            end
          end
        end
        CS_HOLD: begin
          if (half_end) begin
            hcnt    <= '0;
            state   <= IDLE;
            spi_csn <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            hcnt <= hcnt + CLK_DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: directed cases plus randomized transactions against a length/bit-level model.
module tb_spi_master_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, quad_en;
  logic [7:0]  clk_div;
  logic [5:0]  tx_len, rx_len;
  logic [31:0] tx_data, rx_data;
  logic        busy, done, spi_clk, spi_csn;
  logic [3:0]  spi_sdo, spi_oe, spi_sdi;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.CLK_DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .quad_en(quad_en), .clk_div(clk_div),
    .tx_len(tx_len), .rx_len(rx_len), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .spi_clk(spi_clk), .spi_csn(spi_csn),
    .spi_sdo(spi_sdo), .spi_oe(spi_oe), .spi_sdi(spi_sdi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int len, input bit q);
    int l;
    l = (len > 32) ? 32 : len;
    if (q) l = l - (l % 4);
    return l;
  endfunction

  // Slave data for RX group j: the lr-bit word rxw is sent MSB-first in groups of step bits.
  function automatic logic [3:0] sdi_grp(input int j, input bit q, input int lr, input logic [31:0] rxw);
    logic [31:0] v;
    int step;
    logic [3:0] junk;
    step = q ? 4 : 1;
    junk = 4'($urandom);
    if (j * step >= lr) return junk;
    v = rxw >> (lr - step * (j + 1));
    return q ? v[3:0] : {junk[3:1], v[0]};
  endfunction

  task automatic run_txn(input string tag, input bit q, input int div, input int tl, input int rl,
                         input logic [31:0] txd, input logic [31:0] rxw, input bit ghost);
    int step, lt, lr, h, n, exp_done, done_cyc, ndone, rises, rxi;
    logic [63:0] txcap;
    logic [31:0] exp_tx, exp_rx;
    bit csn_ok, line_ok, sdo_ok, oe_seen;
    logic prev_clk;
    logic [3:0] prev_sdo;
    step = q ? 4 : 1;
    lt = eff(tl, q);
    lr = eff(rl, q);
    h = div + 1;
    n = (lt + lr) / step;
    exp_done = 1 + h * (2 + 2 * n);
    exp_tx = (lt == 0) ? 32'h0 : 32'(64'(txd) >> (32 - lt));
    exp_rx = (lr == 0) ? 32'h0 : 32'(64'(rxw) & ((64'd1 << lr) - 64'd1));
    done_cyc = 0; ndone = 0; rises = 0; rxi = 0; txcap = '0;
    csn_ok = 1; line_ok = 1; sdo_ok = 1; oe_seen = 0;
    prev_clk = spi_clk;
    prev_sdo = spi_sdo;
    spi_sdi = sdi_grp(0, q, lr, rxw);
    quad_en = q; clk_div = 8'(div); tx_len = 6'(tl); rx_len = 6'(rl); tx_data = txd;
    start = 1'b1;
    for (int cyc = 1; cyc <= exp_done + 40; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc == 0 && spi_csn !== 1'b0) csn_ok = 0;
      if (done_cyc != 0 && spi_csn !== 1'b1) csn_ok = 0;
      if (spi_oe !== 4'h0) oe_seen = 1;
      if (spi_clk === 1'b1 && spi_sdo !== prev_sdo) sdo_ok = 0;
      if (spi_clk === 1'b1 && prev_clk === 1'b0) begin
        rises++;
        if (spi_oe !== 4'h0) begin
          txcap = q ? ((txcap << 4) | 64'(spi_sdo)) : ((txcap << 1) | 64'(spi_sdo[0]));
          if (spi_oe !== (q ? 4'hF : 4'h1) || (!q && spi_sdo[3:1] !== 3'b000)) line_ok = 0;
        end else begin
          rxi++;
          spi_sdi = sdi_grp(rxi, q, lr, rxw);
        end
      end
      prev_clk = spi_clk;
      prev_sdo = spi_sdo;
      if (ghost && busy === 1'b1) begin
        tx_data = $urandom; tx_len = 6'($urandom); rx_len = 6'($urandom);
        quad_en = 1'($urandom); clk_div = 8'($urandom);
        if (cyc == 2) start = 1'b1;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    chk({tag, ":done_cycle"}, done_cyc, exp_done);
    chk({tag, ":done_count"}, ndone, 1);
    chk({tag, ":spi_clk_rises"}, rises, n);
    chk({tag, ":tx_bits"}, txcap[31:0], exp_tx);
    chk({tag, ":rx_data"}, rx_data, exp_rx);
    chk({tag, ":csn_window"}, 32'(csn_ok), 1);
    chk({tag, ":tx_lines"}, 32'(line_ok), 1);
    chk({tag, ":sdo_stable_high"}, 32'(sdo_ok), 1);
    if (lt == 0) chk({tag, ":oe_never_on"}, 32'(oe_seen), 0);
    chk({tag, ":busy_after"}, 32'(busy), 0);
  endtask

  initial begin
    int rises, ndone, nclk;
    bit found;
    logic prev_clk;
    rst = 1'b1; start = 1'b0; quad_en = 1'b0; clk_div = '0;
    tx_len = '0; rx_len = '0; tx_data = '0; spi_sdi = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:csn", 32'(spi_csn), 1);
    chk("reset:spi_clk", 32'(spi_clk), 0);
    chk("reset:sdo", 32'(spi_sdo), 0);
    chk("reset:oe", 32'(spi_oe), 0);
    chk("reset:busy", 32'(busy), 0);
    chk("reset:done", 32'(done), 0);
    chk("reset:rx_data", rx_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn("std_write", 0, 0, 8, 0, 32'hA500_0000, 32'h0, 0);
    run_txn("std_read", 0, 0, 0, 16, 32'h1234_5678, 32'h0000_BEEF, 0);
    run_txn("quad_wr_rd", 1, 2, 8, 8, 32'h3C00_0000, 32'h0000_0096, 0);
    run_txn("zero_len", 0, 1, 0, 0, 32'hFFFF_FFFF, 32'h0, 0);
    run_txn("clamp_ghost", 0, 0, 40, 0, 32'hDEAD_BEEF, 32'h0, 1);
    run_txn("quad_full", 1, 1, 63, 35, 32'hCAFE_F00D, 32'h8765_4321, 1);

    // Abort during the fifth TX bit: after four rises, once spi_clk is low again.
    quad_en = 1'b0; clk_div = 8'd1; tx_len = 6'd16; rx_len = 6'd0; tx_data = 32'hF0F0_AAAA;
    start = 1'b1;
    rises = 0; found = 0; prev_clk = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (spi_clk === 1'b1 && prev_clk === 1'b0) rises++;
      prev_clk = spi_clk;
      if (rises == 4 && spi_clk === 1'b0) begin
        found = 1;
        break;
      end
    end
    chk("rst_mid:reached_bit5", 32'(found), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid:csn", 32'(spi_csn), 1);
    chk("rst_mid:busy", 32'(busy), 0);
    chk("rst_mid:done", 32'(done), 0);
    chk("rst_mid:spi_clk", 32'(spi_clk), 0);
    ndone = 0; nclk = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
      if (spi_clk !== 1'b0) nclk++;
    end
    chk("rst_mid:no_done_after", ndone, 0);
    chk("rst_mid:no_spi_clk_after", nclk, 0);
    run_txn("after_rst", 0, 1, 12, 4, 32'h5A5A_0000, 32'h0000_000B, 0);

    for (int i = 0; i < 40; i++) begin
      run_txn($sformatf("rand%0d", i), 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 40), $urandom_range(0, 40), $urandom, $urandom,
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV_W, default 8, meaning the width of the clk_div input.
REQ-002 SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-004 SHALL have port start  input  1  meaning a transaction request, accepted only in IDLE.
REQ-005 SHALL have port quad_en  input  1  meaning 0 selects standard (1 bit per SPI clock) and 1 selects quad (4 bits per SPI clock).
REQ-006 SHALL have port clk_div  input  CLK_DIV_W  meaning the SPI half-period is H = clk_div+1 clk cycles.
REQ-007 SHALL have ports tx_len and rx_len  input  6 each  meaning the bit counts to transmit and to receive, in the range 0..32.
REQ-008 SHALL have port tx_data  input  32  meaning the transmit word, left-aligned so that bit 31 is sent first.
REQ-009 SHALL have port rx_data  output  32  meaning the received bits, right-aligned with the last received bit at bit 0.
REQ-010 SHALL have ports busy and done  output  1 each  meaning busy is high outside IDLE and done is a single-cycle completion pulse.
REQ-011 SHALL have ports spi_clk and spi_csn  output  1 each  meaning the SPI clock (mode 0, idle low) and the active-low chip select.
REQ-012 SHALL have ports spi_sdo and spi_oe  output  4 each  meaning the data lines and their per-line output enables.
REQ-013 SHALL have port spi_sdi  input  4  meaning the receive data lines.

Function
REQ-014 SHALL implement the states IDLE, CS_SETUP, TX, RX and CS_HOLD.
REQ-015 SHALL, on start in IDLE, latch tx_data, tx_len, rx_len, quad_en and clk_div, clear rx_data, and enter CS_SETUP on the next edge; start outside IDLE SHALL be ignored.
REQ-016 SHALL clamp tx_len and rx_len values above 32 to 32.
REQ-017 SHALL, in quad mode, ignore the two LSBs of tx_len and rx_len (floor to a multiple of 4).
REQ-018 SHALL drive spi_csn low for the whole time the controller is in CS_SETUP, TX, RX and CS_HOLD.
REQ-019 SHALL, in CS_SETUP, hold spi_clk low for H cycles with the first TX bit(s) already driven.
REQ-020 SHALL make each SPI clock H cycles low followed by H cycles high.
REQ-021 SHALL change spi_sdo only while spi_clk is low, and SHALL sample spi_sdi on the clk edge at which spi_clk rises.
REQ-022 SHALL, in standard TX, drive spi_sdo[0] MSB-first with spi_oe = 4'b0001.
REQ-023 SHALL, in quad TX, drive spi_sdo[3:0] = the next 4 bits (bit n on line 3) with spi_oe = 4'b1111.
REQ-024 SHALL, in RX, set spi_oe = 4'b0000 and shift in spi_sdi[0] (standard) or spi_sdi[3:0] (quad, line 3 is the MSB) until rx_len bits are received.
REQ-025 SHALL go TX->RX when rx_len>0, and otherwise TX->CS_HOLD; a state whose length is 0 SHALL be skipped.
REQ-026 SHALL, in CS_HOLD, hold spi_clk low for H cycles and then return to IDLE with spi_csn high and done pulsed for one cycle.
REQ-027 SHALL give the latency: start sampled at cycle 0 -> done at cycle 1 + H*(2 + 2N), where N is the total number of SPI clocks.
REQ-028 SHALL keep rx_data stable from done until the next accepted start.
REQ-029 SHALL change no input-latched parameter mid-transaction; input changes while busy SHALL have no effect.

Reset
REQ-030 SHALL, with rst high at a clk edge, give the following outputs on the next cycle: state IDLE, spi_csn=1, spi_clk=0, spi_sdo=0, spi_oe=0, busy=0, done=0, rx_data=0.
REQ-031 SHALL, on reset mid-transaction, abort immediately without a done pulse and without any further spi_clk edge.

Verification
REQ-032 SHALL cover std write: clk_div=0, tx_len=8, tx_data=32'hA5000000, rx_len=0 -> 8 rising spi_clk edges sampling 1,0,1,0,0,1,0,1; done at cycle 19.
REQ-033 SHALL cover std read: tx_len=0, rx_len=16, spi_sdi[0] driven with 16'hBEEF MSB-first -> rx_data=32'h0000BEEF; spi_oe=0 throughout.
REQ-034 SHALL cover quad write then read: quad_en=1, clk_div=2, tx_len=8 with 32'h3C000000, rx_len=8 with sdi nibbles 4'h9 then 4'h6 -> sdo nibbles 3 then C, rx_data=32'h96, done at cycle 1+3*(2+8)=31.
REQ-035 SHALL cover the zero-length case: tx_len=0, rx_len=0, clk_div=1 -> spi_csn low for 4 cycles, no spi_clk edge, done at cycle 5.
REQ-036 SHALL cover clamping and ignored start: tx_len=40 -> exactly 32 SPI clocks; a second start pulsed while busy -> exactly one done.
REQ-037 SHALL cover reset mid-transaction: rst asserted during the 5th TX bit -> next cycle spi_csn=1, busy=0, no done; a fresh start afterwards completes normally.
